fft1d_mul_pipe: RTL
===================

Name: fft1d_mul_pipe

Overview:
- Parametrised, pipelined fixed-point multiplier for the FFT datapath (twiddle × sample). Successor to the combinational signed×zero-extended-unsigned multiplier.
- Adds configurable latency, a per-operand signedness mode, fixed-point realignment with round-half-up, output saturation, a clock-enable stall, and valid/tag tracking through the pipe.
- Sits between the butterfly operand fetch and the add/sub stage.

Parameters:
DIN0_WIDTH, 64, operand 0 width
DIN1_WIDTH, 63, operand 1 width
DOUT_WIDTH, 64, result width
NUM_STAGE, 3, total latency in cycles (>=1)
DIN0_SIGNED, 1, 1 = din0 two's complement, 0 = unsigned
DIN1_SIGNED, 0, 1 = din1 two's complement, 0 = unsigned (zero-extended)
SHIFT, 62, right shift applied to the full product (fixed-point alignment, 0..P-1)
ROUND, 1, 1 = round half-up before the shift (ignored when SHIFT=0)
SATURATE, 1, 1 = clamp to the DOUT range, 0 = wrap (truncate)
TAG_WIDTH, 4, sideband tag width (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ce  in  1  clock enable; low freezes every pipeline register
in_valid  in  1  din0/din1/in_tag carry a beat (sampled only when ce=1)
din0  in  DIN0_WIDTH  operand 0
din1  in  DIN1_WIDTH  operand 1
in_tag  in  TAG_WIDTH  sideband carried alongside the beat
out_valid  out  1  dout/sat/out_tag hold a new result this cycle
dout  out  DOUT_WIDTH  aligned, rounded, saturated product
sat  out  1  saturation occurred for this result
out_tag  out  TAG_WIDTH  in_tag of this result

Behaviour:
- Reset is synchronous and active-high on clk. It clears out_valid, dout, sat, out_tag and all internal valid bits to 0. In-flight beats are discarded. Reset overrides ce=0.
- Product width is P = DIN0_WIDTH + DIN1_WIDTH, which is exact for every signedness mix.
  - Each operand is extended per its SIGNED parameter.
  - The product is signed if either operand is signed; otherwise it is unsigned.
  - dout uses the same signedness.
- Alignment:
  - If ROUND=1 and SHIFT>0, add 2^(SHIFT-1) to the product. Internal width P+1 prevents overflow.
  - Then shift right by SHIFT: arithmetic if the product is signed, logical otherwise.
- Saturation, when SATURATE=1:
  - If the value exceeds the DOUT range, dout is clamped to max/min and sat=1; otherwise sat=0.
  - When SATURATE=0, dout takes the low DOUT_WIDTH bits and sat=0.
- Latency: a beat accepted at edge k (ce=1, in_valid=1) appears with out_valid=1 after edge k+NUM_STAGE-1. This counts ce=1 edges only; ce=0 cycles extend latency 1:1.
- Stage mapping:
  - Stage 1 registers the operands. The multiply sits between stage 1 and stage 2.
  - Stages beyond 2 delay the product.
  - Round and saturate are computed combinationally into the final register.
  - With NUM_STAGE=1, the whole path is combinational into one output register.
- Valid and tag shift alongside the data. Bubbles (in_valid=0) propagate as out_valid=0.
- The dout, sat and out_tag registers load only when a valid beat exits. They hold their values across bubbles and ce=0.
- With ce=0, out_valid holds its current value. A result presented when ce drops stays presented; the downstream stage is gated by the same ce.
- Back-to-back accepts have a throughput of 1 beat per ce cycle. There is no backpressure other than ce.
- Arithmetic is fully deterministic with no X propagation after reset; inputs are ignored when in_valid=0.

Decomposition:
- Shared package fft1d_mul_pkg:
  - Product-width function.
  - Saturation max/min constant functions per DOUT_WIDTH and signedness.
  - Rounding-constant function.
- One natural sub-module, fft1d_mul_round_sat: combinational P-bit → DOUT_WIDTH align/round/saturate with a sat flag. It is also reusable in the butterfly adder.
- Pipeline depth is handled by a generate loop in the top.

Test Plan:
(config for all tests: DIN0=14, DIN1=12, DOUT=16, SHIFT=8, NUM_STAGE=3, ROUND=1, SAT=1, DIN0_SIGNED=1, DIN1_SIGNED=0)
1. din0=1000, din1=200, tag=5 → out_valid after 3 ce edges, dout=781, sat=0, out_tag=5.
2. Rounding: din0=1, din1=128 → dout=1; din0=-1, din1=128 → dout=0 (half-up toward +inf).
3. Saturation: din0=8191, din1=4095 → dout=32767, sat=1; din0=-8192, din1=4095 → dout=-32768, sat=1.
4. Unsigned operand: din1=12'h800 with din0=2 → dout=16 (din1 treated as +2048, not negative).
5. Stream 8 beats with tags 0..7, ce=0 for 2 cycles mid-stream → results in order with correct values. Latency of affected beats is 5; out_valid holds during the stall; outputs are unchanged while ce=0.
6. Three beats in flight, then reset for 1 cycle → none of them ever produces out_valid. All outputs read 0 after reset. A beat accepted next appears exactly 3 cycles later.

Source files
------------

// File: rtl/fft1d_mul_pkg.sv
// Shared constants and constant functions for the FFT multiplier datapath.
// Latency: n/a (package only).
// Backpressure: n/a.
package fft1d_mul_pkg;

  // Wide enough to hold any saturation/rounding constant we build at elaboration.
  localparam int MAXW = 256;

  // Full-precision product width; exact for any signed/unsigned operand mix.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

  // Largest representable result for a DOUT of width dw.
  function automatic logic signed [MAXW-1:0] sat_max(input int dw, input bit sgn);
    logic signed [MAXW-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    if (sgn) return (one <<< (dw - 1)) - one;
    return (one <<< dw) - one;
  endfunction

  // Smallest representable result for a DOUT of width dw.
  function automatic logic signed [MAXW-1:0] sat_min(input int dw, input bit sgn);
    logic signed [MAXW-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    if (sgn) return -(one <<< (dw - 1));
    return '0;
  endfunction

  // Half an output LSB, added before the right shift to round half-up.
  function automatic logic signed [MAXW-1:0] round_const(input int shift, input bit rnd);
    logic signed [MAXW-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    if (rnd && shift > 0) return one <<< (shift - 1);
    return '0;
  endfunction

endpackage

// File: rtl/fft1d_mul_round_sat.sv
// Fixed-point realignment of a full product: round half-up, shift, saturate/wrap.
// Latency: combinational.
// Backpressure: none (pure function of i_prod).
module fft1d_mul_round_sat
  import fft1d_mul_pkg::*;
#(
  parameter int P_WIDTH    = 127,
  parameter int DOUT_WIDTH = 64,
  parameter int SIGNED     = 1,
  parameter int SHIFT      = 62,
  parameter int ROUND      = 1,
  parameter int SATURATE   = 1
) (
  input  logic [P_WIDTH-1:0]    i_prod,
  output logic [DOUT_WIDTH-1:0] o_dout,
  output logic                  o_sat
);

  // Two guard bits: one absorbs the rounding carry, one keeps unsigned values positive
  // so a single signed comparison covers both signedness modes.
  localparam int Q = P_WIDTH + 2;
  localparam logic signed [Q-1:0] C_RND = Q'(round_const(SHIFT, ROUND != 0));
  localparam logic signed [Q-1:0] C_MAX = Q'(sat_max(DOUT_WIDTH, SIGNED != 0));
  localparam logic signed [Q-1:0] C_MIN = Q'(sat_min(DOUT_WIDTH, SIGNED != 0));

  logic                w_msb;
  logic signed [Q-1:0] w_ext;
  logic signed [Q-1:0] w_rnd;
  logic signed [Q-1:0] w_shf;

  assign w_msb = (SIGNED != 0) & i_prod[P_WIDTH-1];
  assign w_ext = {{2{w_msb}}, i_prod};
  assign w_rnd = w_ext + C_RND;
  // Arithmetic shift; unsigned products are non-negative here, so it acts as logical.
  assign w_shf = w_rnd >>> SHIFT;

  // Clamp to the output range or wrap by truncation.
  always_comb begin
    o_dout = w_shf[DOUT_WIDTH-1:0];
    o_sat  = 1'b0;
    if (SATURATE != 0) begin
      if (w_shf > C_MAX) begin
        o_dout = C_MAX[DOUT_WIDTH-1:0];
        o_sat  = 1'b1;
      end else if (w_shf < C_MIN) begin
        o_dout = C_MIN[DOUT_WIDTH-1:0];
        o_sat  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft1d_mul_pipe.sv
// Pipelined twiddle x sample multiplier with realignment, saturation and tag tracking.
// Latency: NUM_STAGE ce-enabled cycles from accept to out_valid.
// Backpressure: none; ce=0 freezes every register, throughput 1 beat per ce cycle.
module fft1d_mul_pipe
  import fft1d_mul_pkg::*;
#(
  parameter int DIN0_WIDTH  = 64,
  parameter int DIN1_WIDTH  = 63,
  parameter int DOUT_WIDTH  = 64,
  parameter int NUM_STAGE   = 3,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 62,
  parameter int ROUND       = 1,
  parameter int SATURATE    = 1,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int P      = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int PROD_S = (DIN0_SIGNED != 0 || DIN1_SIGNED != 0) ? 1 : 0;

  logic [P-1:0]          w_x0;
  logic [P-1:0]          w_x1;
  logic [P-1:0]          w_prod;
  logic                  w_fv;
  logic [TAG_WIDTH-1:0]  w_ftag;
  logic [DOUT_WIDTH-1:0] w_dout;
  logic                  w_sat;

  // Extending both operands to P bits makes the low P bits of the product exact.
  assign w_x0 = {{(P-DIN0_WIDTH){(DIN0_SIGNED != 0) & din0[DIN0_WIDTH-1]}}, din0};
  assign w_x1 = {{(P-DIN1_WIDTH){(DIN1_SIGNED != 0) & din1[DIN1_WIDTH-1]}}, din1};

  generate
    if (NUM_STAGE == 1) begin : g_comb
      assign w_prod = w_x0 * w_x1;
      assign w_fv   = in_valid;
      assign w_ftag = in_tag;
    end else begin : g_pipe
      logic [P-1:0]         r_a;
      logic [P-1:0]         r_b;
      logic                 r_v1;
      logic [TAG_WIDTH-1:0] r_t1;
      logic [P-1:0]         w_pd [NUM_STAGE-1];
      logic                 w_vd [NUM_STAGE-1];
      logic [TAG_WIDTH-1:0] w_td [NUM_STAGE-1];

      // Operand register; data only captured for valid beats.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_v1 <= 1'b0;
          r_a  <= '0;
          r_b  <= '0;
          r_t1 <= '0;
        end else if (ce) begin
          r_v1 <= in_valid;
          if (in_valid) begin
            r_a  <= w_x0;
            r_b  <= w_x1;
            r_t1 <= in_tag;
          end
        end
      end

      assign w_pd[0] = r_a * r_b;
      assign w_vd[0] = r_v1;
      assign w_td[0] = r_t1;

      for (genvar i = 1; i < NUM_STAGE - 1; i++) begin : g_dly
        logic [P-1:0]         r_p;
        logic                 r_v;
        logic [TAG_WIDTH-1:0] r_t;

        // Product delay stage carrying valid and tag alongside.
        always_ff @(posedge clk) begin
          if (reset) begin
            r_v <= 1'b0;
            r_p <= '0;
            r_t <= '0;
          end else if (ce) begin
            r_v <= w_vd[i-1];
            if (w_vd[i-1]) begin
              r_p <= w_pd[i-1];
              r_t <= w_td[i-1];
            end
          end
        end

        assign w_pd[i] = r_p;
        assign w_vd[i] = r_v;
        assign w_td[i] = r_t;
      end

      assign w_prod = w_pd[NUM_STAGE-2];
      assign w_fv   = w_vd[NUM_STAGE-2];
      assign w_ftag = w_td[NUM_STAGE-2];
    end
  endgenerate

  fft1d_mul_round_sat #(
    .P_WIDTH    (P),
    .DOUT_WIDTH (DOUT_WIDTH),
    .SIGNED     (PROD_S),
    .SHIFT      (SHIFT),
    .ROUND      (ROUND),
    .SATURATE   (SATURATE)
  ) u_round_sat (
    .i_prod (w_prod),
    .o_dout (w_dout),
    .o_sat  (w_sat)
  );

  // Output register; result fields hold across bubbles and stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sat       <= 1'b0;
      out_tag   <= '0;
    end else if (ce) begin
      out_valid <= w_fv;
      if (w_fv) begin
        dout    <= w_dout;
        sat     <= w_sat;
        out_tag <= w_ftag;
      end
    end
  end

endmodule
